// File: rtl/sram_controller_pkg.sv
// Shared widths, state encodings and the latched request record for the
// Mem-stage SRAM controller.
package sram_controller_pkg;
  localparam int WORD_LEN      = 32;
  localparam int ADDRESS_LEN   = 32;
  localparam int SRAM_ADDR_LEN = 18;
  localparam int SRAM_DATA_LEN = 16;

  localparam logic [1:0] SRAM_IDLE = 2'd0;
  localparam logic [1:0] SRAM_LO   = 2'd1;
  localparam logic [1:0] SRAM_HI   = 2'd2;
  localparam logic [1:0] SRAM_DONE = 2'd3;

  typedef struct packed {
    logic                     op_wr;
    logic [SRAM_ADDR_LEN-2:0] word;
    logic [WORD_LEN-1:0]      wdata;
  } sram_req_t;
endpackage

// File: rtl/sram_controller_if.sv
// Mem-stage request/response handshake plus the board SRAM pins.
interface sram_controller_if;
  import sram_controller_pkg::*;

  logic                     wr_en;
  logic                     rd_en;
  logic [ADDRESS_LEN-1:0]   address;
  logic [WORD_LEN-1:0]      write_data;
  logic [WORD_LEN-1:0]      read_data;
  logic                     ready;
  logic [SRAM_ADDR_LEN-1:0] sram_addr;
  logic [SRAM_DATA_LEN-1:0] sram_dq_out;
  logic [SRAM_DATA_LEN-1:0] sram_dq_in;
  logic                     sram_dq_oe;
  logic                     sram_we_n;

  modport master (
    output wr_en, rd_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport slave (
    input  wr_en, rd_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/sram_beat_counter.sv
// Per-beat cycle counter: clear wins over enable, terminal count at
// WAIT_CYCLES-1. The next value is exported so outputs can be registered.
module sram_beat_counter #(
  parameter int WAIT_CYCLES = 3,
  localparam int CW = $clog2(WAIT_CYCLES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic [CW-1:0] cnt_d_o,
  output logic          tc_o
);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o   = cnt_q;
  assign cnt_d_o = cnt_d;
  assign tc_o    = (cnt_q == CW'(WAIT_CYCLES - 1));
endmodule

// File: rtl/sram_controller.sv
// Services one 32-bit Mem-stage access as two 16-bit beats on an async SRAM;
// ready stays low until the access completes and freezes the pipeline.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int                     WAIT_CYCLES = 3,
  parameter logic [ADDRESS_LEN-1:0] BASE_ADDR   = 32'd1024
) (
  input  logic               clk,
  input  logic               rst,
  sram_controller_if.slave   bus
);
  localparam int            CW   = $clog2(WAIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  logic [1:0]               state_q, state_d;
  sram_req_t                req_q, req_d;
  logic [WORD_LEN-1:0]      rdata_q, rdata_d;
  logic [SRAM_ADDR_LEN-1:0] addr_q, addr_d;
  logic [SRAM_DATA_LEN-1:0] dq_q, dq_d;
  logic                     oe_q, oe_d, we_n_q, we_n_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     tc, in_beat_q, in_beat_d, req;
  logic [ADDRESS_LEN-1:0]   offset;
  logic                     unused_offset;

  assign req           = bus.wr_en | bus.rd_en;
  assign offset        = bus.address - BASE_ADDR;
  assign unused_offset = ^{offset[ADDRESS_LEN-1:SRAM_ADDR_LEN+1], offset[1:0]};

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    case (state_q)
      SRAM_IDLE: if (req) begin
        state_d     = SRAM_LO;
        req_d.op_wr = bus.wr_en;
        req_d.word  = offset[SRAM_ADDR_LEN:2];
        req_d.wdata = bus.write_data;
      end
      SRAM_LO:   if (tc) state_d = SRAM_HI;
      SRAM_HI:   if (tc) state_d = SRAM_DONE;
      default:   state_d = SRAM_IDLE;
    endcase
  end

  assign in_beat_q = (state_q == SRAM_LO) || (state_q == SRAM_HI);
  assign in_beat_d = (state_d == SRAM_LO) || (state_d == SRAM_HI);

  sram_beat_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (state_d != state_q),
    .en_i    (in_beat_q),
    .cnt_o   (cnt_q),
    .cnt_d_o (cnt_d),
    .tc_o    (tc)
  );

  // Pins are decoded from next state so they change only on clk edges.
  always_comb begin
    addr_d = addr_q;
    dq_d   = dq_q;
    oe_d   = 1'b0;
    we_n_d = 1'b1;
    if (in_beat_d) begin
      addr_d = {req_d.word, state_d == SRAM_HI};
      dq_d   = (state_d == SRAM_HI) ? req_d.wdata[31:16] : req_d.wdata[15:0];
      oe_d   = req_d.op_wr;
      we_n_d = ~(req_d.op_wr && (cnt_d != LAST));
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (!req_q.op_wr && tc) begin
      if (state_q == SRAM_LO)      rdata_d[15:0]  = bus.sram_dq_in;
      else if (state_q == SRAM_HI) rdata_d[31:16] = bus.sram_dq_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= SRAM_IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      dq_q    <= '0;
      oe_q    <= 1'b0;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      dq_q    <= dq_d;
      oe_q    <= oe_d;
      we_n_q  <= we_n_d;
    end
  end

  always_comb begin
    case (state_q)
      SRAM_DONE: bus.ready = 1'b1;
      SRAM_IDLE: bus.ready = ~req;
      default:   bus.ready = 1'b0;
    endcase
  end

  assign bus.read_data   = rdata_q;
  assign bus.sram_addr   = addr_q;
  assign bus.sram_dq_out = dq_q;
  assign bus.sram_dq_oe  = oe_q;
  assign bus.sram_we_n   = we_n_q;
endmodule

// File: tb/tb_sram_controller.sv
// Directed bench: W=3 controller for write/read/priority/abort/wrap, and a
// W=2 controller for back-to-back stall counting, each with a 16-entry SRAM.
module tb_sram_controller;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  sram_controller_if m3();
  sram_controller_if m2();

  sram_controller #(.WAIT_CYCLES(3), .BASE_ADDR(32'd1024)) u_dut3 (
    .clk(clk), .rst(rst), .bus(m3.slave));
  sram_controller #(.WAIT_CYCLES(2), .BASE_ADDR(32'd1024)) u_dut2 (
    .clk(clk), .rst(rst), .bus(m2.slave));

  logic [15:0] mem3 [16] = '{default: 16'h0};
  logic [15:0] mem2 [16] = '{default: 16'h0};

  assign m3.sram_dq_in = mem3[m3.sram_addr[3:0]];
  assign m2.sram_dq_in = mem2[m2.sram_addr[3:0]];

  always @(posedge clk) begin
    if (!m3.sram_we_n) mem3[m3.sram_addr[3:0]] <= m3.sram_dq_out;
    if (!m2.sram_we_n) mem2[m2.sram_addr[3:0]] <= m2.sram_dq_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of the IDLE cycle that carries the request.
  task automatic run3(input bit wr, input logic [17:0] a0, input logic [31:0] wd,
                      input logic [31:0] rd_exp);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk("ready3", 32'(m3.ready), 32'(c == 7));
      if (c <= 6) begin
        chk("addr3", 32'(m3.sram_addr), 32'((c <= 3) ? a0 : a0 + 18'd1));
        chk("oe3", 32'(m3.sram_dq_oe), 32'(wr));
        chk("we_n3", 32'(m3.sram_we_n), 32'(!(wr && c != 3 && c != 6)));
        if (wr) chk("dq3", 32'(m3.sram_dq_out), 32'((c <= 3) ? wd[15:0] : wd[31:16]));
      end else begin
        chk("rdata3", m3.read_data, rd_exp);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    m3.wr_en = 0; m3.rd_en = 0; m3.address = 0; m3.write_data = 0;
    m2.wr_en = 0; m2.rd_en = 0; m2.address = 0; m2.write_data = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(m3.ready), 32'd1);
    chk("rst_rdata", m3.read_data, 32'd0);
    chk("rst_addr", 32'(m3.sram_addr), 32'd0);
    chk("rst_dq", 32'(m3.sram_dq_out), 32'd0);
    chk("rst_oe", 32'(m3.sram_dq_oe), 32'd0);
    chk("rst_we_n", 32'(m3.sram_we_n), 32'd1);
    rst = 1;

    // Write 0xDEADBEEF to byte 1024
    @(negedge clk);
    m3.wr_en = 1; m3.address = 32'd1024; m3.write_data = 32'hDEADBEEF;
    #1 chk("idle_req_ready", 32'(m3.ready), 32'd0);
    run3(1'b1, 18'd0, 32'hDEADBEEF, 32'd0);
    m3.wr_en = 0; m3.write_data = 32'h0;
    @(negedge clk);
    chk("idle_ready", 32'(m3.ready), 32'd1);
    chk("mem3_0", 32'(mem3[0]), 32'h0000BEEF);
    chk("mem3_1", 32'(mem3[1]), 32'h0000DEAD);

    // Read it back
    m3.rd_en = 1;
    run3(1'b0, 18'd0, 32'h0, 32'hDEADBEEF);
    m3.rd_en = 0;
    @(negedge clk);

    // Both requests: write wins, read_data untouched
    m3.wr_en = 1; m3.rd_en = 1; m3.address = 32'd1028; m3.write_data = 32'h12345678;
    run3(1'b1, 18'd2, 32'h12345678, 32'hDEADBEEF);
    m3.wr_en = 0; m3.rd_en = 0;
    @(negedge clk);
    chk("mem3_2", 32'(mem3[2]), 32'h00005678);
    chk("mem3_3", 32'(mem3[3]), 32'h00001234);

    // Reset pulse during cycle 4 of a read, then re-issue
    m3.rd_en = 1; m3.address = 32'd1028;
    repeat (4) @(negedge clk);
    chk("abort_hi_addr", 32'(m3.sram_addr), 32'd3);
    rst = 0;
    @(negedge clk);
    chk("abort_ready", 32'(m3.ready), 32'd0);
    chk("abort_rdata", m3.read_data, 32'd0);
    chk("abort_we_n", 32'(m3.sram_we_n), 32'd1);
    chk("abort_oe", 32'(m3.sram_dq_oe), 32'd0);
    rst = 1;
    run3(1'b0, 18'd2, 32'h0, 32'h12345678);
    m3.rd_en = 0;
    @(negedge clk);

    // Wrap-around: 1024 + 2^19 aliases to SRAM word 0
    m3.rd_en = 1; m3.address = 32'd1024 + 32'h0008_0000;
    run3(1'b0, 18'd0, 32'h0, 32'hDEADBEEF);
    m3.rd_en = 0;
    @(negedge clk);

    // Back-to-back write then read, W=2
    m2.wr_en = 1; m2.address = 32'd1032; m2.write_data = 32'hCAFEF00D;
    #1;
    n = 0;
    while (m2.ready !== 1'b1 && n < 20) begin
      n++;
      if (n == 2) chk("b2b_we_n_c1", 32'(m2.sram_we_n), 32'd0);
      if (n == 3) chk("b2b_we_n_c2", 32'(m2.sram_we_n), 32'd1);
      @(negedge clk);
    end
    chk("b2b_wr_stall", 32'(n), 32'd5);
    m2.wr_en = 0; m2.rd_en = 1;
    @(negedge clk);
    chk("b2b_no_gap", 32'(m2.ready), 32'd0);
    n = 0;
    while (m2.ready !== 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("b2b_rd_stall", 32'(n), 32'd5);
    chk("b2b_rdata", m2.read_data, 32'hCAFEF00D);
    chk("b2b_addr_hi", 32'(m2.sram_addr), 32'd5);
    m2.rd_en = 0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
